// File: rtl/subtractor_seq64_if.sv
// Operand/result handshake bundle for the sequential subtractor.
// The slave side is the subtractor; the master side is its producer/consumer.
interface subtractor_seq64_if #(
  parameter int WIDTH = 64
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             zero;
  logic             overflow;

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, diff, borrow, zero, overflow
  );

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, diff, borrow, zero, overflow
  );
endinterface

// File: rtl/subtractor_seq64.sv
// Multi-cycle two's-complement subtractor: one SLICE-bit adder is reused each
// cycle to form a + ~b + 1, with the carry rippled between slices.
module subtractor_seq64 #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  subtractor_seq64_if.slave  bus
);
  localparam int NSL  = WIDTH / SLICE;
  localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [IDXW-1:0]   idx_q;
  logic              carry_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  nb_q;
  logic [WIDTH-1:0]  diff_q;
  logic              borrow_q;
  logic              zero_q;
  logic              overflow_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic [SLICE:0]    sum_d;
  logic [WIDTH-1:0]  diff_d;
  logic              last_slice_s;

  // Current slice sum and the diff word as it will look once this slice lands
  always_comb begin
    sum_d  = {1'b0, a_q[idx_q*SLICE +: SLICE]}
           + {1'b0, nb_q[idx_q*SLICE +: SLICE]}
           + {{SLICE{1'b0}}, carry_q};
    diff_d = diff_q;
    diff_d[idx_q*SLICE +: SLICE] = sum_d[SLICE-1:0];
    last_slice_s = (idx_q == IDXW'(NSL - 1));
  end

  // Control FSM with all datapath and flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= {IDXW{1'b0}};
      carry_q     <= 1'b0;
      a_q         <= {WIDTH{1'b0}};
      nb_q        <= {WIDTH{1'b0}};
      diff_q      <= {WIDTH{1'b0}};
      borrow_q    <= 1'b0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= bus.a;
            nb_q       <= ~bus.b;
            carry_q    <= 1'b1;
            idx_q      <= {IDXW{1'b0}};
            diff_q     <= {WIDTH{1'b0}};
            in_ready_q <= 1'b0;
            state_q    <= CALC;
          end
        end
        CALC: begin
          diff_q  <= diff_d;
          carry_q <= sum_d[SLICE];
          if (last_slice_s) begin
            // Final slice: sum_d[SLICE-1] is the result sign bit
            borrow_q    <= ~sum_d[SLICE];
            zero_q      <= (diff_d == {WIDTH{1'b0}});
            overflow_q  <= (a_q[WIDTH-1] != ~nb_q[WIDTH-1])
                        && (sum_d[SLICE-1] != a_q[WIDTH-1]);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            idx_q <= idx_q + {{(IDXW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;
  assign bus.borrow    = borrow_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_subtractor_seq64.sv
// Directed bench for subtractor_seq64: reset values, arithmetic vectors,
// latency, backpressure hold and reset in the middle of a calculation.
module tb_subtractor_seq64;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  subtractor_seq64_if #(.WIDTH(64)) bus();

  subtractor_seq64 #(.WIDTH(64), .SLICE(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = 64'h0;
    bus.b = 64'h0;
    #12;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", bus.in_ready, bus.out_valid);
    end
    total++;
    if (bus.diff !== 64'h0 || bus.borrow !== 1'b0 || bus.zero !== 1'b0 || bus.overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset_data: diff=%h b=%b z=%b o=%b want all 0", bus.diff, bus.borrow, bus.zero, bus.overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Issue one subtraction, check latency, result, flags and the consume handshake
  task automatic test_vector(input string name, input logic [63:0] va, input logic [63:0] vb,
                             input logic [63:0] ed, input logic eb, input logic ez, input logic eo);
    int cnt;
    @(negedge clk);
    bus.a = va;
    bus.b = vb;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.a = ~va;
    bus.b = 64'hDEAD_BEEF_0BAD_F00D;
    total++;
    if (bus.in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s_accept: in_ready=%b want 0", name, bus.in_ready);
    end
    cnt = 0;
    while (bus.out_valid !== 1'b1 && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    total++;
    if (cnt !== 4) begin
      bad++;
      $display("FAIL %s_latency: cycles=%0d want 4", name, cnt);
    end
    total++;
    if (bus.diff !== ed) begin
      bad++;
      $display("FAIL %s_diff: got %h want %h", name, bus.diff, ed);
    end
    total++;
    if ({bus.borrow, bus.zero, bus.overflow} !== {eb, ez, eo}) begin
      bad++;
      $display("FAIL %s_flags: bzo=%b%b%b want %b%b%b", name, bus.borrow, bus.zero, bus.overflow, eb, ez, eo);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_consume: out_valid=%b in_ready=%b want 0/1", name, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_arith();
    test_vector("sub5_3", 64'd5, 64'd3, 64'd2, 1'b0, 1'b0, 1'b0);
    test_vector("sub0_1", 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);
    test_vector("ripple", 64'h0001_0000_0000_0000, 64'd1, 64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
    test_vector("minovf", 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1);
    test_vector("equal", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'h0, 1'b0, 1'b1, 1'b0);
    test_vector("maxovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_backpressure();
    int cnt;
    @(negedge clk);
    bus.a = 64'd10;
    bus.b = 64'd4;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    cnt = 0;
    while (bus.out_valid !== 1'b1 && cnt < 20) begin
      bus.a = bus.a + 64'd7;
      bus.b = bus.b + 64'd100;
      @(posedge clk);
      #1;
      cnt++;
    end
    for (int i = 0; i < 10; i++) begin
      bus.a = 64'h0 + 64'(i);
      bus.b = 64'hFFFF_0000_0000_0000 + 64'(i);
      @(negedge clk);
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.diff !== 64'd6
          || {bus.borrow, bus.zero, bus.overflow} !== 3'b000) begin
        bad++;
        $display("FAIL hold_%0d: ov=%b ir=%b diff=%h bzo=%b%b%b want 1/0/6/000", i,
                 bus.out_valid, bus.in_ready, bus.diff, bus.borrow, bus.zero, bus.overflow);
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.diff !== 64'd6) begin
      bad++;
      $display("FAIL hold_release: ov=%b ir=%b diff=%h want 0/1/6", bus.out_valid, bus.in_ready, bus.diff);
    end
  endtask

  task automatic test_reset_mid_calc();
    @(negedge clk);
    bus.a = 64'h5555_5555_5555_5555;
    bus.b = 64'h1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.diff !== 64'h0) begin
      bad++;
      $display("FAIL midreset: ov=%b ir=%b diff=%h want 0/1/0", bus.out_valid, bus.in_ready, bus.diff);
    end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (bus.out_valid !== 1'b0) begin
      bad++;
      $display("FAIL midreset_hold: out_valid=%b want 0", bus.out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_vector("after_rst", 64'd100, 64'd1, 64'd99, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid_calc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
